// File: rtl/clk_pkg.sv
// Shared clocking-supervisor types, default timing constants and width helper.
package clk_pkg;

  typedef enum logic [2:0] {
    RST_PULSE = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } wd_state_e;

  localparam int unsigned RST_CYC_DEF      = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF = 100000;
  localparam int unsigned STABLE_CYC_DEF   = 1024;
  localparam int unsigned MAX_RETRY_DEF    = 4;
  localparam int unsigned CNT_W_DEF        = 8;

  // Counter width able to hold (largest period - 1); never narrower than one bit.
  function automatic int unsigned cnt_w_f(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return unsigned'($clog2(m));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchroniser with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mmcm_lock_watchdog.sv
// Drives the clocking wizard reset from the board clock, supervises its locked
// output and reissues reset on lock timeout or lock loss.
module mmcm_lock_watchdog
  import clk_pkg::*;
#(
  parameter int unsigned RST_CYC      = RST_CYC_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYC   = STABLE_CYC_DEF,
  parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clki,
  input  logic             rsti,
  input  logic             locked,
  input  logic             force_req,
  output logic             mmcm_rst,
  output logic             lock_ok,
  output logic [CNT_W-1:0] relock_cnt,
  output logic             fail,
  output logic [2:0]       state_o
);

  localparam int unsigned TW = cnt_w_f(RST_CYC, LOCK_TIMEOUT, STABLE_CYC);
  localparam int unsigned RW = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST  = TW'(STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam bit            RETRY_BOUNDED = (MAX_RETRY != 0);

  wd_state_e        state;
  logic [TW-1:0]    cnt;
  logic [RW-1:0]    retry_cnt;
  logic [RW-1:0]    retry_nxt;
  logic [CNT_W-1:0] relock_nxt;
  logic             lk_s;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clki),
    .rst_n (rsti),
    .d     (locked),
    .q     (lk_s)
  );

  // Both counts saturate rather than wrap.
  assign retry_nxt  = (&retry_cnt)  ? retry_cnt  : retry_cnt + RW'(1);
  assign relock_nxt = (&relock_cnt) ? relock_cnt : relock_cnt + CNT_W'(1);
  assign state_o    = state;

  always_ff @(posedge clki) begin
    if (!rsti) begin
      state      <= RST_PULSE;
      cnt        <= '0;
      retry_cnt  <= '0;
      relock_cnt <= '0;
      mmcm_rst   <= 1'b1;
      lock_ok    <= 1'b0;
      fail       <= 1'b0;
    end else begin
      unique case (state)
        RST_PULSE: begin
          if (cnt == RST_LAST) begin
            state    <= WAIT_LOCK;
            cnt      <= '0;
            mmcm_rst <= 1'b0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end

        WAIT_LOCK: begin
          if (force_req) begin
            state      <= RST_PULSE;
            cnt        <= '0;
            mmcm_rst   <= 1'b1;
            relock_cnt <= relock_nxt;
          end else if (lk_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            cnt       <= '0;
            retry_cnt <= retry_nxt;
            if (RETRY_BOUNDED && (retry_nxt == RETRY_LIM)) begin
              state <= FAIL;
              fail  <= 1'b1;
            end else begin
              state      <= RST_PULSE;
              mmcm_rst   <= 1'b1;
              relock_cnt <= relock_nxt;
            end
          end else begin
            cnt <= cnt + TW'(1);
          end
        end

        STABLE: begin
          if (force_req) begin
            state      <= RST_PULSE;
            cnt        <= '0;
            mmcm_rst   <= 1'b1;
            relock_cnt <= relock_nxt;
          end else if (!lk_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            retry_cnt <= '0;
            lock_ok   <= 1'b1;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end

        RUN: begin
          if (force_req || !lk_s) begin
            state      <= RST_PULSE;
            cnt        <= '0;
            mmcm_rst   <= 1'b1;
            lock_ok    <= 1'b0;
            relock_cnt <= relock_nxt;
          end
        end

        FAIL: begin
          if (force_req) begin
            state      <= RST_PULSE;
            cnt        <= '0;
            retry_cnt  <= '0;
            mmcm_rst   <= 1'b1;
            fail       <= 1'b0;
            relock_cnt <= relock_nxt;
          end
        end

        // Illegal encodings recover through a fresh reset pulse.
        default: begin
          state    <= RST_PULSE;
          cnt      <= '0;
          mmcm_rst <= 1'b1;
          lock_ok  <= 1'b0;
          fail     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_lock_watchdog.sv
// Directed bench for mmcm_lock_watchdog with a cycle-level behavioural model
// compared on every falling edge, plus hand-computed timing checks.
module tb_mmcm_lock_watchdog;

  localparam int unsigned RST_CYC      = 4;
  localparam int unsigned LOCK_TIMEOUT = 20;
  localparam int unsigned STABLE_CYC   = 8;
  localparam int unsigned MAX_RETRY    = 3;
  localparam int unsigned CNT_W        = 8;
  localparam int          RELOCK_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rsti;
  logic             locked;
  logic             force_req;
  logic             mmcm_rst;
  logic             lock_ok;
  logic [CNT_W-1:0] relock_cnt;
  logic             fail;
  logic [2:0]       state_o;

  int n_vec = 0;
  int n_bad = 0;

  mmcm_lock_watchdog #(
    .RST_CYC      (RST_CYC),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYC   (STABLE_CYC),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (CNT_W)
  ) dut (
    .clki       (clk),
    .rsti       (rsti),
    .locked     (locked),
    .force_req  (force_req),
    .mmcm_rst   (mmcm_rst),
    .lock_ok    (lock_ok),
    .relock_cnt (relock_cnt),
    .fail       (fail),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: phase number, edges spent in it, synchroniser pipe, retry and relock tallies.
  int m_phase = 0;
  int m_age   = 0;
  int m_retry = 0;
  int m_relock = 0;
  int m_s1 = 0;
  int m_s2 = 0;
  bit m_valid = 1'b0;

  task automatic m_enter(input int p);
    m_phase = p;
    m_age   = 0;
  endtask

  task automatic m_relock_go();
    m_relock = (m_relock < RELOCK_MAX) ? m_relock + 1 : RELOCK_MAX;
    m_enter(0);
  endtask

  initial forever begin
    int lk;
    @(posedge clk);
    if (!rsti) begin
      m_enter(0);
      m_retry  = 0;
      m_relock = 0;
      m_s1     = 0;
      m_s2     = 0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      lk    = m_s2;
      m_s2  = m_s1;
      m_s1  = int'(locked);
      m_age = m_age + 1;
      case (m_phase)
        0: if (m_age == RST_CYC) m_enter(1);
        1: begin
          if (force_req) m_relock_go();
          else if (lk != 0) m_enter(2);
          else if (m_age == LOCK_TIMEOUT) begin
            m_retry = m_retry + 1;
            if (MAX_RETRY != 0 && m_retry == MAX_RETRY) m_enter(4);
            else m_relock_go();
          end
        end
        2: begin
          if (force_req) m_relock_go();
          else if (lk == 0) m_enter(1);
          else if (m_age == STABLE_CYC) begin
            m_retry = 0;
            m_enter(3);
          end
        end
        3: if (force_req || lk == 0) m_relock_go();
        4: if (force_req) begin
          m_retry = 0;
          m_relock_go();
        end
        default: m_enter(0);
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("state_o",    state_o,    m_phase);
      chk("mmcm_rst",   mmcm_rst,   int'(m_phase == 0));
      chk("lock_ok",    lock_ok,    int'(m_phase == 3));
      chk("fail",       fail,       int'(m_phase == 4));
      chk("relock_cnt", relock_cnt, m_relock);
    end
  end

  task automatic wait_state(input int s, input int lim, input string name);
    int n;
    n = 0;
    while (state_o !== 3'(s) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, state_o, s);
  endtask

  task automatic pulse_len(output int n);
    n = 0;
    while (mmcm_rst === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic state_len(input int s, output int n);
    n = 0;
    while (state_o === 3'(s) && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit got=%0d exp=%0d", n_vec, 0);
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int hi;
    rsti = 1'b0; locked = 1'b0; force_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",  state_o, 0);
    chk("rst_mmcm",   mmcm_rst, 1);
    chk("rst_lockok", lock_ok, 0);
    chk("rst_fail",   fail, 0);
    chk("rst_relock", relock_cnt, 0);

    // Bring-up: pulse width, then lock rise to lock_ok.
    rsti = 1'b1;
    pulse_len(n);
    chk("init_pulse_len", n, 4);
    repeat (5) @(negedge clk);
    locked = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!lock_ok && n < 40);
    // two sync edges, one WAIT_LOCK decision edge, eight STABLE cycles
    chk("lock_ok_latency", n, 11);
    chk("init_relock", relock_cnt, 0);

    // One-cycle lock drop while running.
    locked = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; if (n == 1) locked = 1'b1; end while (lock_ok && n < 20);
    chk("lockloss_latency", n, 3);
    pulse_len(n);
    chk("lockloss_pulse_len", n, 4);
    chk("lockloss_relock", relock_cnt, 1);
    wait_state(3, 60, "relock_run");
    chk("relock_lock_ok", lock_ok, 1);

    // Glitch during STABLE returns to WAIT_LOCK without a relock.
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    wait_state(2, 40, "reach_stable");
    repeat (4) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    wait_state(1, 10, "glitch_to_wait");
    chk("glitch_lock_ok", lock_ok, 0);
    chk("glitch_relock", relock_cnt, 2);
    wait_state(3, 60, "glitch_recover_run");

    // force_req on the final timeout cycle yields one relock only.
    locked = 1'b0;
    wait_state(1, 40, "reach_wait");
    repeat (19) @(negedge clk);
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    chk("force_tmo_state", state_o, 0);
    chk("force_tmo_relock", relock_cnt, 4);
    pulse_len(n);
    chk("force_tmo_pulse_len", n, 4);

    // Reset asserted in the middle of WAIT_LOCK.
    repeat (5) @(negedge clk);
    rsti = 1'b0;
    @(negedge clk);
    chk("midrst_mmcm", mmcm_rst, 1);
    chk("midrst_relock", relock_cnt, 0);
    chk("midrst_state", state_o, 0);
    rsti = 1'b1;

    // Lock never arrives: three timeouts then FAIL.
    for (int k = 0; k < 3; k++) begin
      pulse_len(n);
      chk("retry_pulse_len", n, 4);
      state_len(1, n);
      chk("retry_wait_len", n, 20);
    end
    chk("fail_flag", fail, 1);
    chk("fail_state", state_o, 4);
    chk("fail_relock", relock_cnt, 2);
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mmcm_rst !== 1'b0) hi++;
    end
    chk("fail_mmcm_quiet", hi, 0);

    // Software relock out of FAIL; a second request mid-pulse is ignored.
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    chk("fail_clear", fail, 0);
    chk("fail_force_relock", relock_cnt, 3);
    chk("fail_force_mmcm", mmcm_rst, 1);
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    pulse_len(n);
    chk("pulse_ignore_force_rest", n, 3);
    chk("pulse_ignore_force_relock", relock_cnt, 3);

    // Saturation of the relock count.
    for (int k = 0; k < 300; k++) begin
      wait_state(1, 20, "sat_wait");
      force_req = 1'b1;
      @(negedge clk);
      force_req = 1'b0;
    end
    chk("relock_saturate", relock_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
